// File: rtl/alu_op_sequencer.sv
// ALU issue sequencer: buffers operation requests in a small FIFO, drives them
// one at a time into a combinational ALU, and returns registered results in
// order over a valid/ready response port.
module alu_op_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CTRW  = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [WIDTH-1:0]         req_a,
  input  logic [WIDTH-1:0]         req_b,
  input  logic [CTRW-1:0]          req_ctr,
  output logic [WIDTH-1:0]         alu_busa,
  output logic [WIDTH-1:0]         alu_busb,
  output logic [CTRW-1:0]          alu_aluctr,
  input  logic [WIDTH-1:0]         alu_result,
  input  logic                     alu_zero,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_zero,
  output logic [3:0]               rsp_seq,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 2 * WIDTH + CTRW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [EW-1:0]     r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  logic [WIDTH-1:0]  r_alu_busa;
  logic [WIDTH-1:0]  r_alu_busb;
  logic [CTRW-1:0]   r_alu_aluctr;
  logic              r_rsp_valid;
  logic [WIDTH-1:0]  r_rsp_result;
  logic              r_rsp_zero;
  logic [3:0]        r_rsp_seq;

  logic              w_push;
  logic              w_load;
  logic              w_capture;
  logic              w_rsp_done;
  logic              w_not_empty;
  logic [EW-1:0]     w_head;

  // Readiness comes only from the registered count, so a full FIFO never
  // accepts a push even if a pop happens on the same edge.
  assign req_ready   = (r_count != CW'(DEPTH));
  assign w_push      = req_valid && req_ready;
  assign w_not_empty = (r_count != '0);
  assign w_head      = r_mem[r_rd_ptr];

  // Next-state and control strobes for the issue/capture/respond sequence
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    w_rsp_done  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_not_empty) begin
          w_load      = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        w_capture   = 1'b1;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (r_rsp_valid && rsp_ready) begin
          w_rsp_done = 1'b1;
          if (w_not_empty) begin
            w_load      = 1'b1;
            w_state_nxt = S_EXEC;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FIFO storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {req_a, req_b, req_ctr};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_load) r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_push, w_load})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ALU operand registers; change only when a new op is issued
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alu_busa   <= '0;
      r_alu_busb   <= '0;
      r_alu_aluctr <= '0;
    end else if (w_load) begin
      r_alu_busa   <= w_head[EW-1 -: WIDTH];
      r_alu_busb   <= w_head[CTRW +: WIDTH];
      r_alu_aluctr <= w_head[CTRW-1:0];
    end
  end

  // Response capture, handshake and completion sequence number
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_seq    <= '0;
    end else begin
      if (w_capture) begin
        r_rsp_valid  <= 1'b1;
        r_rsp_result <= alu_result;
        r_rsp_zero   <= alu_zero;
      end else if (w_rsp_done) begin
        r_rsp_valid  <= 1'b0;
      end
      if (w_rsp_done) r_rsp_seq <= r_rsp_seq + 4'd1;
    end
  end

  assign alu_busa   = r_alu_busa;
  assign alu_busb   = r_alu_busb;
  assign alu_aluctr = r_alu_aluctr;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_zero   = r_rsp_zero;
  assign rsp_seq    = r_rsp_seq;
  assign fifo_count = r_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU on the alu_* ports.
module tb_alu_op_sequencer;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [2:0]  req_ctr;
  logic [31:0] alu_busa;
  logic [31:0] alu_busb;
  logic [2:0]  alu_aluctr;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic [3:0]  rsp_seq;
  logic [2:0]  fifo_count;

  int n_vec;
  int n_err;
  int cyc;
  int n_rsp;
  int last_cyc;
  int gap_on;
  int gap_have;
  logic [3:0]  exp_seq;
  logic [3:0]  last_seq;
  logic [32:0] exp_q[$];

  alu_op_sequencer #(.WIDTH(32), .CTRW(3), .DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ctr    (req_ctr),
    .alu_busa   (alu_busa),
    .alu_busb   (alu_busb),
    .alu_aluctr (alu_aluctr),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_seq    (rsp_seq),
    .fifo_count (fifo_count)
  );

  // Behavioural ALU: 0 add, 1 sub, 2 and, 3 or, others xor
  always_comb begin
    case (alu_aluctr)
      3'd0:    alu_result = alu_busa + alu_busb;
      3'd1:    alu_result = alu_busa - alu_busb;
      3'd2:    alu_result = alu_busa & alu_busb;
      3'd3:    alu_result = alu_busa | alu_busb;
      default: alu_result = alu_busa ^ alu_busb;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Score any response that will be consumed on the coming edge, then advance
  task automatic step();
    logic [32:0] e;
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_result", rsp_result, e[31:0]);
        check("sb_zero", 32'(rsp_zero), 32'(e[32]));
        check("sb_seq", 32'(rsp_seq), 32'(exp_seq));
        last_seq = rsp_seq;
        exp_seq  = exp_seq + 4'd1;
        n_rsp++;
        if (gap_on != 0 && gap_have != 0) check("sb_gap", 32'(cyc - last_cyc), 32'd2);
        last_cyc = cyc;
        gap_have = 1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c,
                      input logic [31:0] er, input logic ez);
    int w;
    w = 0;
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_ctr   = c;
    while (!req_ready && w < 100) begin
      step();
      w++;
    end
    if (!req_ready) check("push_timeout", 32'(req_ready), 32'd1);
    exp_q.push_back({ez, er});
    step();
    req_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      step();
      w++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_result"}, rsp_result, 32'd0);
    check({tag, "_rsp_zero"}, 32'(rsp_zero), 32'd0);
    check({tag, "_rsp_seq"}, 32'(rsp_seq), 32'd0);
    check({tag, "_busa"}, alu_busa, 32'd0);
    check({tag, "_busb"}, alu_busb, 32'd0);
    check({tag, "_aluctr"}, 32'(alu_aluctr), 32'd0);
    check({tag, "_count"}, 32'(fifo_count), 32'd0);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    check_reset_state("rst");
    exp_q.delete();
    exp_seq  = 4'd0;
    n_rsp    = 0;
    gap_have = 0;
    reset    = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; n_rsp = 0; last_cyc = 0;
    gap_on = 0; gap_have = 0; exp_seq = 4'd0; last_seq = 4'd0;
    reset = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_ctr = '0;
    rsp_ready = 1'b0;
    #1;

    // 1: reset state
    do_reset();

    // 2: single addu, latency of two edges after accept
    rsp_ready = 1'b1;
    push(32'h800F0000, 32'h0003C000, 3'b000, 32'h8012C000, 1'b0);
    check("t2_valid_k0", 32'(rsp_valid), 32'd0);
    step();
    check("t2_valid_k1", 32'(rsp_valid), 32'd0);
    check("t2_busa", alu_busa, 32'h800F0000);
    check("t2_busb", alu_busb, 32'h0003C000);
    step();
    check("t2_valid_k2", 32'(rsp_valid), 32'd1);
    check("t2_result", rsp_result, 32'h8012C000);
    check("t2_zero", 32'(rsp_zero), 32'd0);
    check("t2_seq", 32'(rsp_seq), 32'd0);
    step();
    check("t2_valid_after", 32'(rsp_valid), 32'd0);
    check("t2_seq_after", 32'(rsp_seq), 32'd1);
    check("t2_busa_hold", alu_busa, 32'h800F0000);

    // 3: carry-out wraps to zero
    push(32'hFFFFFFFF, 32'h00000001, 3'b000, 32'h00000000, 1'b1);
    step();
    step();
    check("t3_valid", 32'(rsp_valid), 32'd1);
    check("t3_result", rsp_result, 32'h00000000);
    check("t3_zero", 32'(rsp_zero), 32'd1);
    check("t3_seq", 32'(rsp_seq), 32'd1);
    step();

    // 4: stalled consumer, fill to DEPTH+1 outstanding
    do_reset();
    rsp_ready = 1'b0;
    push(32'h00000005, 32'h00000003, 3'd0, 32'h00000008, 1'b0);
    push(32'h00000010, 32'h00000010, 3'd1, 32'h00000000, 1'b1);
    push(32'hF0F0F0F0, 32'h0FF00FF0, 3'd2, 32'h00F000F0, 1'b0);
    push(32'h12340000, 32'h00005678, 3'd3, 32'h12345678, 1'b0);
    push(32'hAAAAAAAA, 32'hFFFFFFFF, 3'd4, 32'h55555555, 1'b0);
    req_valid = 1'b1;
    req_a     = 32'h7FFFFFFF;
    req_b     = 32'h00000001;
    req_ctr   = 3'd0;
    check("t4_full_ready", 32'(req_ready), 32'd0);
    check("t4_full_count", 32'(fifo_count), 32'd4);
    check("t4_valid", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_stall_result", rsp_result, 32'h00000008);
      check("t4_stall_count", 32'(fifo_count), 32'd4);
      check("t4_stall_busa", alu_busa, 32'h00000005);
    end

    // 5: release consumer; 6th enters on first pop, in-order responses
    exp_q.push_back({1'b0, 32'h80000000});
    rsp_ready = 1'b1;
    gap_on    = 1;
    gap_have  = 0;
    step();
    check("t5_ready_on_pop", 32'(req_ready), 32'd1);
    check("t5_count_on_pop", 32'(fifo_count), 32'd3);
    step();
    req_valid = 1'b0;
    check("t5_count_after_push", 32'(fifo_count), 32'd4);
    drain("t5_drain6");
    check("t5_nrsp6", 32'(n_rsp), 32'd6);
    gap_on = 0;
    for (int i = 0; i < 11; i++) begin
      push(32'(i), 32'(3 * i), 3'd0, 32'(4 * i), (i == 0));
    end
    drain("t5_drain17");
    check("t5_nrsp17", 32'(n_rsp), 32'd17);
    check("t5_seq17_wrap", 32'(last_seq), 32'd0);
    check("t5_seq_after", 32'(rsp_seq), 32'd1);

    // 6: asynchronous reset mid-cycle with work outstanding
    rsp_ready = 1'b0;
    push(32'd1, 32'd1, 3'd0, 32'd2, 1'b0);
    push(32'd2, 32'd2, 3'd0, 32'd4, 1'b0);
    push(32'd3, 32'd3, 3'd0, 32'd6, 1'b0);
    push(32'd4, 32'd4, 3'd0, 32'd8, 1'b0);
    check("t6_pre_valid", 32'(rsp_valid), 32'd1);
    check("t6_pre_count", 32'(fifo_count), 32'd3);
    check("t6_pre_seq", 32'(rsp_seq), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_valid", 32'(rsp_valid), 32'd0);
    check("t6_async_count", 32'(fifo_count), 32'd0);
    check("t6_async_seq", 32'(rsp_seq), 32'd0);
    check("t6_async_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    do_reset();
    step();
    step();
    check("t6_idle_valid", 32'(rsp_valid), 32'd0);
    check("t6_idle_count", 32'(fifo_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
